// File: rtl/snoop_dedup_push_arbiter_pkg.sv
// Shared types and default sizes for the snoop/dedup push arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snoop_arb_pkg;

    localparam int DEF_DATA_W = 164;
    localparam int DEF_NREQ   = 4;
    localparam int DEF_CNT_W  = 16;
    localparam int ID_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        CHECK = 2'd2,
        PUSH  = 2'd3
    } state_t;

endpackage

// File: rtl/snoop_dedup_push_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; en=0 forces no grant and leaves the pointer unchanged.
module rr_arbiter
    import snoop_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic [ID_W-1:0] ptr_nxt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic             found;
    logic [IDX_W-1:0] sel;
    int               pos;

    // Walk NREQ slots starting at ptr; the first pending one wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        sel     = '0;
        pos     = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            sel = IDX_W'(pos);
            if (en && !found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                gnt_id   = ID_W'(pos);
                ptr_nxt  = (pos == NREQ - 1) ? '0 : ID_W'(pos + 1);
            end
        end
    end

endmodule

// File: rtl/snoop_dedup_push_arbiter.sv
// Arbitrates NREQ requesters onto a snoopable FIFO: snoop, then push only on a miss.
// Latency: 4 cycles per pushed entry (IDLE/SNOOP/CHECK/PUSH), 3 per dropped duplicate.
// Backpressure: holds wvalid/wdata in PUSH until fifo_wready; requesters wait on req_ready.
module snoop_dedup_push_arbiter
    import snoop_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREQ   = DEF_NREQ,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    output logic [DATA_W-1:0]      fifo_wdata,
    output logic                   fifo_wvalid,
    input  logic                   fifo_wready,
    output logic [DATA_W-1:0]      fifo_sdata,
    output logic                   fifo_svalid,
    input  logic                   fifo_smatch,
    output logic                   dup_valid,
    output logic [ID_W-1:0]        dup_id,
    output logic [CNT_W-1:0]       push_cnt,
    output logic [CNT_W-1:0]       dup_cnt,
    output logic                   busy
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   entry_q;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     ptr_q;
    logic [NREQ-1:0]     gnt;
    logic [ID_W-1:0]     gnt_id;
    logic [ID_W-1:0]     ptr_nxt;
    logic [DATA_W-1:0]   win_data;
    logic                ack;
    logic                grant_fire;
    logic                push_fire;
    logic                dup_fire;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (state_q == IDLE),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .ptr_nxt (ptr_nxt)
    );

    // Select the winning requester's slice using the one-hot grant.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant_fire = |gnt;
    assign push_fire  = (state_q == PUSH)  && fifo_wready;
    assign dup_fire   = (state_q == CHECK) && fifo_smatch;

    // Next state and per-state handshake outputs; a reset cycle suppresses consume pulses
    // so an abandoned entry is never acknowledged.
    always_comb begin
        state_d     = state_q;
        fifo_svalid = 1'b0;
        fifo_wvalid = 1'b0;
        dup_valid   = 1'b0;
        ack         = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    state_d = SNOOP;
                end
            end
            SNOOP: begin
                fifo_svalid = 1'b1;
                state_d     = CHECK;
            end
            CHECK: begin
                if (fifo_smatch) begin
                    dup_valid = 1'b1;
                    ack       = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = PUSH;
                end
            end
            PUSH: begin
                fifo_wvalid = 1'b1;
                if (fifo_wready) begin
                    ack     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            dup_valid = 1'b0;
            ack       = 1'b0;
        end
    end

    // Decode the consume pulse onto the latched requester id.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ack && (id_q == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    assign dup_id     = dup_valid ? id_q : '0;
    assign fifo_wdata = entry_q;
    assign fifo_sdata = entry_q;
    assign busy       = (state_q != IDLE);

    // State, captured entry, round-robin pointer and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            entry_q  <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
            push_cnt <= '0;
            dup_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                entry_q <= win_data;
                id_q    <= gnt_id;
                ptr_q   <= ptr_nxt;
            end
            if (push_fire && (push_cnt != {CNT_W{1'b1}})) begin
                push_cnt <= push_cnt + CNT_W'(1);
            end
            if (dup_fire && (dup_cnt != {CNT_W{1'b1}})) begin
                dup_cnt <= dup_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_snoop_dedup_push_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for stall/reset/saturation,
// and a randomized run against a transaction-level model with a model FIFO.
module tb_snoop_dedup_push_arbiter;
    import snoop_arb_pkg::*;

    localparam int DW = 164;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   fifo_wdata, fifo_sdata;
    logic            fifo_wvalid, fifo_wready, fifo_svalid, fifo_smatch;
    logic            dup_valid;
    logic [2:0]      dup_id;
    logic [15:0]     push_cnt, dup_cnt;
    logic            busy;

    logic [N-1:0]    s_req_ready;
    logic [DW-1:0]   s_wdata, s_sdata;
    logic            s_wvalid, s_svalid, s_dup_valid, s_busy;
    logic [2:0]      s_dup_id;
    logic [3:0]      s_push_cnt, s_dup_cnt;

    always #5 clk = ~clk;

    snoop_dedup_push_arbiter #(.DATA_W(DW), .NREQ(N), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_ready(req_ready), .fifo_wdata(fifo_wdata), .fifo_wvalid(fifo_wvalid),
        .fifo_wready(fifo_wready), .fifo_sdata(fifo_sdata), .fifo_svalid(fifo_svalid),
        .fifo_smatch(fifo_smatch), .dup_valid(dup_valid), .dup_id(dup_id),
        .push_cnt(push_cnt), .dup_cnt(dup_cnt), .busy(busy)
    );

    snoop_dedup_push_arbiter #(.DATA_W(DW), .NREQ(N), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_ready(s_req_ready), .fifo_wdata(s_wdata), .fifo_wvalid(s_wvalid),
        .fifo_wready(fifo_wready), .fifo_sdata(s_sdata), .fifo_svalid(s_svalid),
        .fifo_smatch(fifo_smatch), .dup_valid(s_dup_valid), .dup_id(s_dup_id),
        .push_cnt(s_push_cnt), .dup_cnt(s_dup_cnt), .busy(s_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester-side model state, shared by all phases.
    logic [DW-1:0] rd [N];
    logic [N-1:0]  rv;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = rd[i];
        req_valid = rv;
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; rv = '0; fifo_smatch = 1'b0; fifo_wready = 1'b0;
        repeat (2) begin cyc(); apply(); end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [DW-1:0] pick();
        logic [31:0] hi;
        hi = 32'($urandom_range(1, 6));
        return {hi, 132'd0} | DW'($urandom_range(0, 1));
    endfunction

    typedef struct {
        logic [N-1:0] vld; logic wr; logic sm;
        logic sv; logic wv; logic [N-1:0] rdy; logic dv; logic [2:0] did; logic bsy;
    } vec_t;
    vec_t tbl [9];

    // Random-phase model variables.
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] prev_data [N];
    logic [DW-1:0] svc_entry, last_sdata;
    logic [N-1:0]  prev_vld, ack_prev, ack_now;
    int            stage, st, mptr, svc_id, push_n, dup_n, w;
    logic          was_idle_prev, last_sv, exp_dup, exp_sv, hit;

    int gid [$];
    int gcy [$];
    int sv_n, dups;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) rd[i] = '0;
        req_data = '0; req_valid = '0;

        // Reset state.
        do_reset();
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_svalid", DW'(fifo_svalid), DW'(0));
        chk("rst_wvalid", DW'(fifo_wvalid), DW'(0));
        chk("rst_ready", DW'(req_ready), DW'(0));
        chk("rst_dup", DW'(dup_valid), DW'(0));
        chk("rst_dup_id", DW'(dup_id), DW'(0));
        chk("rst_push_cnt", DW'(push_cnt), DW'(0));
        chk("rst_dup_cnt", DW'(dup_cnt), DW'(0));
        chk("rst_wdata", fifo_wdata, DW'(0));

        // Single push from r0, then duplicate from r2 with the same data.
        tbl[0] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0};
        tbl[1] = '{4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1};
        tbl[2] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1};
        tbl[3] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 3'd0, 1'b1};
        tbl[4] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0};
        tbl[5] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0};
        tbl[6] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1};
        tbl[7] = '{4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 3'd2, 1'b1};
        tbl[8] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0};
        rd[0] = DW'(8'hA5); rd[1] = DW'(8'hB1); rd[2] = DW'(8'hA5); rd[3] = DW'(8'hC3);
        for (int i = 0; i < 9; i++) begin
            cyc();
            rst = 1'b0;
            rv = tbl[i].vld; fifo_wready = tbl[i].wr; fifo_smatch = tbl[i].sm;
            apply();
            chk($sformatf("vec%0d_svalid", i), DW'(fifo_svalid), DW'(tbl[i].sv));
            chk($sformatf("vec%0d_wvalid", i), DW'(fifo_wvalid), DW'(tbl[i].wv));
            chk($sformatf("vec%0d_ready", i), DW'(req_ready), DW'(tbl[i].rdy));
            chk($sformatf("vec%0d_dup", i), DW'(dup_valid), DW'(tbl[i].dv));
            chk($sformatf("vec%0d_dup_id", i), DW'(dup_id), DW'(tbl[i].did));
            chk($sformatf("vec%0d_busy", i), DW'(busy), DW'(tbl[i].bsy));
            if (tbl[i].sv) chk($sformatf("vec%0d_sdata", i), fifo_sdata, DW'(8'hA5));
            if (tbl[i].wv) chk($sformatf("vec%0d_wdata", i), fifo_wdata, DW'(8'hA5));
        end
        chk("vec_push_cnt", DW'(push_cnt), DW'(1));
        chk("vec_dup_cnt", DW'(dup_cnt), DW'(1));

        // Round-robin fairness: all requesters pending, no matches.
        do_reset();
        cyc(); rst = 1'b0;
        for (int i = 0; i < N; i++) rd[i] = DW'(16 + i);
        rv = 4'hF; fifo_smatch = 1'b0; fifo_wready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) cyc();
            apply();
            if (req_ready != '0) begin
                gid.push_back(idx_of(req_ready));
                gcy.push_back(c);
            end
        end
        chk("rr_count", DW'(gid.size()), DW'(5));
        for (int k = 0; k < gid.size() && k < 5; k++) begin
            chk($sformatf("rr_id%0d", k), DW'(gid[k]), DW'(k % 4));
            chk($sformatf("rr_cycle%0d", k), DW'(gcy[k]), DW'(4 * k + 3));
        end

        // FIFO full stall for 10 cycles in PUSH.
        do_reset();
        cyc(); rst = 1'b0;
        rd[0] = DW'(8'hA5); rv = 4'b0001; fifo_wready = 1'b0; fifo_smatch = 1'b0;
        sv_n = 0;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) cyc();
            fifo_wready = (c == 13);
            if (c == 14) rv = '0;
            apply();
            if (fifo_svalid) sv_n++;
            if (c >= 3 && c <= 12) begin
                chk($sformatf("stall%0d_wvalid", c), DW'(fifo_wvalid), DW'(1));
                chk($sformatf("stall%0d_wdata", c), fifo_wdata, DW'(8'hA5));
                chk($sformatf("stall%0d_ready", c), DW'(req_ready), DW'(0));
            end
            if (c == 13) begin
                chk("stall_ack", DW'(req_ready), DW'(4'b0001));
                chk("stall_ack_wvalid", DW'(fifo_wvalid), DW'(1));
            end
            if (c == 14) begin
                chk("stall_push_cnt", DW'(push_cnt), DW'(1));
                chk("stall_busy", DW'(busy), DW'(0));
            end
        end
        chk("stall_snoops", DW'(sv_n), DW'(1));

        // Reset during CHECK with a pending match: no pulse, request re-served after.
        rd[1] = DW'(8'hB1);
        for (int c = 0; c < 7; c++) begin
            cyc();
            rv = (c <= 5) ? 4'b0010 : 4'b0000;
            fifo_smatch = 1'b1; fifo_wready = 1'b1;
            rst = (c == 2);
            apply();
            if (c == 2) begin
                chk("rstc_ready", DW'(req_ready), DW'(0));
                chk("rstc_dup", DW'(dup_valid), DW'(0));
                chk("rstc_busy_in_check", DW'(busy), DW'(1));
            end
            if (c == 3) begin
                chk("rstc_busy", DW'(busy), DW'(0));
                chk("rstc_svalid", DW'(fifo_svalid), DW'(0));
                chk("rstc_wvalid", DW'(fifo_wvalid), DW'(0));
                chk("rstc_ready2", DW'(req_ready), DW'(0));
                chk("rstc_push_cnt", DW'(push_cnt), DW'(0));
                chk("rstc_dup_cnt", DW'(dup_cnt), DW'(0));
            end
            if (c == 4) begin
                chk("rstc_resnoop", DW'(fifo_svalid), DW'(1));
                chk("rstc_sdata", fifo_sdata, DW'(8'hB1));
            end
            if (c == 5) begin
                chk("rstc_redup", DW'(dup_valid), DW'(1));
                chk("rstc_redup_id", DW'(dup_id), DW'(1));
                chk("rstc_reready", DW'(req_ready), DW'(4'b0010));
            end
        end

        // Saturation: 20 duplicates into the 4-bit-counter instance.
        do_reset();
        cyc(); rst = 1'b0;
        rd[0] = DW'(77); rv = 4'b0001; fifo_smatch = 1'b1; fifo_wready = 1'b1;
        apply();
        dups = 0;
        for (int c = 0; c < 100 && dups < 20; c++) begin
            if (c > 0) begin cyc(); apply(); end
            if (dup_valid) dups++;
        end
        chk("sat_dups", DW'(dups), DW'(20));
        cyc(); rv = '0; apply();
        chk("sat_small_dup_cnt", DW'(s_dup_cnt), DW'(15));
        chk("sat_wide_dup_cnt", DW'(dup_cnt), DW'(20));
        chk("sat_small_push_cnt", DW'(s_push_cnt), DW'(0));

        // Randomized run against the transaction-level model.
        do_reset();
        cyc(); rst = 1'b0;
        fifo_q.delete();
        stage = 0; mptr = 0; push_n = 0; dup_n = 0; svc_id = 0;
        was_idle_prev = 1'b0; last_sv = 1'b0; exp_dup = 1'b0;
        ack_prev = '0; prev_vld = '0; rv = '0; svc_entry = '0; last_sdata = '0;
        for (int i = 0; i < N; i++) prev_data[i] = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) cyc();
            for (int i = 0; i < N; i++) begin
                if (ack_prev[i]) begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    rd[i] = pick();
                end else if (!rv[i] && $urandom_range(0, 3) == 0) begin
                    rv[i] = 1'b1;
                    rd[i] = pick();
                end
            end
            if (fifo_q.size() > 0 && $urandom_range(0, 3) == 0) void'(fifo_q.pop_front());
            hit = 1'b0;
            foreach (fifo_q[k]) if (fifo_q[k] == last_sdata) hit = 1'b1;
            if (last_sv) begin
                fifo_smatch = hit;
                exp_dup = hit;
            end else begin
                fifo_smatch = 1'($urandom_range(0, 1));
            end
            fifo_wready = (fifo_q.size() < 48) && ($urandom_range(0, 2) != 0);
            apply();

            st = stage; ack_now = '0;
            exp_sv = was_idle_prev && (prev_vld != '0);
            chk("rnd_push_cnt", DW'(push_cnt), DW'(push_n));
            chk("rnd_dup_cnt", DW'(dup_cnt), DW'(dup_n));
            if (st == 0) begin
                chk("rnd_svalid", DW'(fifo_svalid), DW'(exp_sv));
                chk("rnd_idle_wvalid", DW'(fifo_wvalid), DW'(0));
                chk("rnd_idle_ready", DW'(req_ready), DW'(0));
                chk("rnd_idle_dup", DW'(dup_valid), DW'(0));
                chk("rnd_idle_busy", DW'(busy), DW'(exp_sv));
                if (exp_sv) begin
                    w = rr_pick(prev_vld, mptr);
                    chk("rnd_sdata", fifo_sdata, prev_data[w]);
                    svc_id = w; svc_entry = prev_data[w];
                    mptr = (w + 1) % N; stage = 1;
                end
            end else if (st == 1) begin
                chk("rnd_chk_svalid", DW'(fifo_svalid), DW'(0));
                chk("rnd_chk_wvalid", DW'(fifo_wvalid), DW'(0));
                chk("rnd_chk_dup", DW'(dup_valid), DW'(exp_dup));
                chk("rnd_chk_dup_id", DW'(dup_id), exp_dup ? DW'(svc_id) : DW'(0));
                chk("rnd_chk_ready", DW'(req_ready), exp_dup ? DW'(1 << svc_id) : DW'(0));
                chk("rnd_chk_busy", DW'(busy), DW'(1));
                if (exp_dup) begin
                    dup_n++; ack_now = N'(1 << svc_id); stage = 0;
                end else begin
                    stage = 2;
                end
            end else begin
                chk("rnd_push_wvalid", DW'(fifo_wvalid), DW'(1));
                chk("rnd_push_wdata", fifo_wdata, svc_entry);
                chk("rnd_push_svalid", DW'(fifo_svalid), DW'(0));
                chk("rnd_push_dup", DW'(dup_valid), DW'(0));
                chk("rnd_push_ready", DW'(req_ready), fifo_wready ? DW'(1 << svc_id) : DW'(0));
                if (fifo_wready) begin
                    fifo_q.push_back(svc_entry);
                    push_n++; ack_now = N'(1 << svc_id); stage = 0;
                end
            end
            was_idle_prev = (st == 0) && !exp_sv;
            last_sv = (st == 0) && exp_sv;
            last_sdata = svc_entry;
            prev_vld = rv;
            for (int i = 0; i < N; i++) prev_data[i] = rd[i];
            ack_prev = ack_now;
        end
        cyc(); rv = '0; apply();
        chk("rnd_final_push_cnt", DW'(push_cnt), DW'(push_n));
        chk("rnd_final_dup_cnt", DW'(dup_cnt), DW'(dup_n));
        chk("rnd_small_push_cnt", DW'(s_push_cnt), DW'((push_n > 15) ? 15 : push_n));
        chk("rnd_small_dup_cnt", DW'(s_dup_cnt), DW'((dup_n > 15) ? 15 : dup_n));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
